// File: rtl/multi_pkg.sv
// multi_pkg: width helpers and channel bundle shared by the multi-cycle source and sink wrappers.
package multi_pkg;
  localparam int CHAN_W = 64;
  typedef struct packed {
    logic [CHAN_W-1:0] data;
    logic              valid;
  } chan_t;
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction
  function automatic int cnt_w(input int depth);
    return clog2(depth + 1);
  endfunction
  // A one-entry FIFO still needs a 1-bit pointer to stay legal.
  function automatic int ptr_w(input int depth);
    return (depth > 1) ? clog2(depth) : 1;
  endfunction
endpackage

// File: rtl/multi_fifo_mem.sv
// multi_fifo_mem: depth x w storage with one write port and an asynchronous read at the head.
module multi_fifo_mem #(
  parameter int W     = 1,
  parameter int DEPTH = 2,
  parameter int PW    = 1
) (
  input  logic          clk,
  input  logic          we,
  input  logic [PW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [PW-1:0] raddr,
  output logic [W-1:0]  rdata
);
  logic [W-1:0] mem [DEPTH];
  always_ff @(posedge clk)
    if (we) mem[waddr] <= wdata;
  assign rdata = mem[raddr];
endmodule

// File: rtl/multi_channel_source.sv
// multi_channel_source: FIFO-backed producer for the VALID/CONSUMED multi-cycle write channel.
module multi_channel_source
  import multi_pkg::*;
#(
  parameter int width = 1,
  parameter int depth = 2,
  localparam int W  = (width == 0) ? 1 : width,
  localparam int CW = cnt_w(depth),
  localparam int PW = ptr_w(depth)
) (
  input  logic          CLK,
  input  logic          RST_N,
  input  logic [W-1:0]  ENQ_DATA,
  input  logic          ENQ_EN,
  output logic          ENQ_READY,
  output logic [W-1:0]  OUT_WRITE,
  output logic          OUT_WRITE_VALID,
  input  logic          OUT_WRITE_CONSUMED,
  output logic [CW-1:0] COUNT,
  output logic          OVERFLOW
);
  logic [CW-1:0] count;
  logic [PW-1:0] head, tail;
  logic [W-1:0]  wdata, rdata;
  logic          push, pop;
  // Wrap by compare so non-power-of-two depths cycle through exactly depth slots.
  function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
    return (p == PW'(depth - 1)) ? '0 : p + PW'(1);
  endfunction
  assign ENQ_READY       = count != CW'(depth);
  assign OUT_WRITE_VALID = count != '0;
  assign COUNT           = count;
  assign push            = ENQ_EN && ENQ_READY;
  assign pop             = OUT_WRITE_VALID && OUT_WRITE_CONSUMED;
  assign wdata           = (width == 0) ? '0 : ENQ_DATA;
  assign OUT_WRITE       = (width == 0) ? '0 : rdata;
  always_ff @(posedge CLK or negedge RST_N)
    if (!RST_N) begin
      count    <= '0;
      head     <= '0;
      tail     <= '0;
      OVERFLOW <= 1'b0;
    end else begin
      count    <= (push && !pop) ? count + CW'(1) : (!push && pop) ? count - CW'(1) : count;
      head     <= pop ? nxt(head) : head;
      tail     <= push ? nxt(tail) : tail;
      OVERFLOW <= OVERFLOW || (ENQ_EN && !ENQ_READY);
    end
  multi_fifo_mem #(.W(W), .DEPTH(depth), .PW(PW)) u_mem (
    .clk   (CLK),
    .we    (push),
    .waddr (tail),
    .wdata (wdata),
    .raddr (head),
    .rdata (rdata)
  );
endmodule
